vote_button_conditioner: RTL and testbench
==========================================

# vote_button_conditioner

Front-end stage for the voting machine that turns four raw, asynchronous candidate push-buttons into clean, single-cycle `candidateN_vote_valid` pulses for the vote counter directly downstream. It synchronises and debounces each button and accepts at most one vote per press. After each accepted vote it enforces a lockout and then a release interval. It rejects simultaneous presses and ignores presses while `mode` selects result display.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised-stable cycles needed to accept a level change; legal range ≥1.
- `LOCKOUT_CYCLES`, 8: cycles after an accepted vote during which all presses are ignored; legal range ≥1.
- `CNT_WIDTH`, 16: width of the debounce and lockout counters; must hold max(DEBOUNCE_CYCLES, LOCKOUT_CYCLES).

Ports:
- `clock` in 1: system clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `mode` in 1: 0 = voting, 1 = result display; presses are not accepted when 1.
- `button1`..`button4` in 1 each: raw asynchronous active-high buttons.
- `candidate1_vote_valid`..`candidate4_vote_valid` out 1 each: registered one-cycle vote pulses; at most one high in any cycle.
- `busy` out 1: high when the FSM is not in IDLE.
- `conflict` out 1: registered one-cycle pulse when a simultaneous press is rejected.

## Operation
- **Synchronisation**
  - Each button passes through a two-flop synchroniser, giving synchronised level `sN`.
- **Debounce**
  - Each button has its own counter `cntN` and debounced level `stableN`.
  - If `sN == stableN`: `cntN <= 0`.
  - Otherwise, if `cntN == DEBOUNCE_CYCLES-1`: `stableN <= sN` and `cntN <= 0`.
  - Otherwise: `cntN <= cntN+1`.
  - A glitch shorter than DEBOUNCE_CYCLES therefore restarts the count and never changes `stableN`.
- **Press event**
  - `pressN` = `stableN` & ~`stableN_d`, where `stableN_d` is `stableN` delayed one cycle.
  - Release edges generate no event.
- **FSM states:** IDLE, LOCKOUT, WAIT_RELEASE.
- **IDLE**
  - With `mode`=0 and exactly one `pressN`: set `candidateN_vote_valid` for one cycle; load the lockout counter with 0; go to LOCKOUT.
  - With `mode`=0 and two or more `pressN` in the same cycle: no valid; `conflict` high for one cycle; go to WAIT_RELEASE.
  - With `mode`=1: press events are discarded; stay in IDLE; no outputs.
- **LOCKOUT**
  - The counter increments each cycle; all presses are ignored.
  - When the counter reaches LOCKOUT_CYCLES-1, go to WAIT_RELEASE.
- **WAIT_RELEASE**
  - Stay until every `stableN` == 0, then go to IDLE.
  - Press events occurring in this state are discarded and are not replayed.
- **`mode` changes**
  - A change in `mode` does not abort LOCKOUT or WAIT_RELEASE. It gates acceptance only in IDLE.
- **Reset**
  - All synchroniser flops, `stableN`, `stableN_d`, and all counters are cleared to 0.
  - The FSM returns to IDLE.
  - All valid outputs, `conflict`, and `busy` are 0 in the cycle after the reset edge.
  - Reset asserted mid-LOCKOUT aborts the lockout; no pending pulse is emitted.
  - A button held through reset is debounced again from `stableN`=0 and counts as a fresh press once `DEBOUNCE_CYCLES` are met.

## Timing
- Raw button first sampled high at edge E0, then held:
  - `sN` is high after E1.
  - `stableN` is high after E(1+DEBOUNCE_CYCLES).
  - `candidateN_vote_valid` is high for exactly the cycle after E(2+DEBOUNCE_CYCLES).
  - With defaults, the valid pulse follows E6.
- `busy` rises on the same edge as the valid pulse.
- LOCKOUT occupies exactly LOCKOUT_CYCLES cycles.
- The earliest possible next accepted vote requires a release, a fresh debounce, and a new press.
- Outputs are registered. No combinational path exists from `buttonN` or `mode` to any output.

## Test plan
- **Single clean press:** D=4, L=8; `button2` held high for 30 cycles, then low.
  - `candidate2_vote_valid` pulses once, 6 edges after first sample.
  - `busy` stays high until 4+2 cycles after release; no other outputs.
- **Bounce:** `button1` toggles at 1–3-cycle intervals for 20 cycles, then holds high.
  - No valid during bouncing.
  - Exactly one `candidate1_vote_valid`, 6 edges after the final stable rise.
- **Simultaneous press:** `button3` and `button4` rise on the same edge.
  - `conflict` pulses once; no valid.
  - `busy` is held until both are released; a later single `button3` press then yields one pulse.
- **Mode gating:** `mode`=1 with a `button1` press gives no valid and no busy. `mode`=0 with a new press gives one pulse. `mode` toggled to 1 during LOCKOUT does not shorten LOCKOUT.
- **Held button and lockout:** `button4` held for 100 cycles gives exactly one pulse. A `button1` press during LOCKOUT is ignored.
- **Reset mid-operation:** reset asserted 3 cycles into LOCKOUT gives all outputs 0 next cycle and FSM in IDLE. A still-held button re-votes after debounce.

Source files
------------

// File: rtl/vote_button_conditioner_if.sv
// Signal bundle between the candidate push-buttons / mode switch and the vote
// counter path. The slave side is the conditioner; the master side drives buttons.
interface vote_button_conditioner_if;
    logic mode;
    logic button1;
    logic button2;
    logic button3;
    logic button4;
    logic candidate1_vote_valid;
    logic candidate2_vote_valid;
    logic candidate3_vote_valid;
    logic candidate4_vote_valid;
    logic busy;
    logic conflict;

    modport slave (
        input  mode,
        input  button1, button2, button3, button4,
        output candidate1_vote_valid, candidate2_vote_valid,
        output candidate3_vote_valid, candidate4_vote_valid,
        output busy,
        output conflict
    );

    modport master (
        output mode,
        output button1, button2, button3, button4,
        input  candidate1_vote_valid, candidate2_vote_valid,
        input  candidate3_vote_valid, candidate4_vote_valid,
        input  busy,
        input  conflict
    );
endinterface

// File: rtl/vote_button_conditioner.sv
// Synchronises and debounces four candidate buttons and emits at most one
// single-cycle vote pulse per press, with lockout and release intervals.
//
// state        | meaning
// IDLE         | accepting a single press while mode = voting
// LOCKOUT      | fixed interval after an accepted vote, all presses ignored
// WAIT_RELEASE | waiting for every debounced button to return low
module vote_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    vote_button_conditioner_if.slave      vote_io
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOCKOUT      = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LO_LAST = CNT_WIDTH'(LOCKOUT_CYCLES - 1);

    logic [3:0]                 raw_buttons;
    logic [3:0]                 sync1_q;
    logic [3:0]                 sync2_q;
    logic [3:0]                 stable_q, stable_d;
    logic [3:0]                 stable_dly_q;
    logic [3:0][CNT_WIDTH-1:0]  db_cnt_q, db_cnt_d;
    logic [3:0]                 press;
    logic                       press_single;
    logic                       press_any;

    state_e                     state_q, state_d;
    logic [CNT_WIDTH-1:0]       lock_cnt_q, lock_cnt_d;
    logic [3:0]                 valid_q, valid_d;
    logic                       conflict_q, conflict_d;

    assign raw_buttons = {vote_io.button4, vote_io.button3, vote_io.button2, vote_io.button1};

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // Rising edges of the debounced levels only; releases produce no event.
    assign press        = stable_q & ~stable_dly_q;
    assign press_any    = (press != 4'b0000);
    assign press_single = press_any && ((press & (press - 4'd1)) == 4'b0000);

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        valid_d    = 4'b0000;
        conflict_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!vote_io.mode) begin
                    if (press_single) begin
                        valid_d    = press;
                        lock_cnt_d = '0;
                        state_d    = LOCKOUT;
                    end else if (press_any) begin
                        conflict_d = 1'b1;
                        state_d    = WAIT_RELEASE;
                    end
                end
            end
            LOCKOUT: begin
                if (lock_cnt_q == LO_LAST) begin
                    state_d = WAIT_RELEASE;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (stable_q == 4'b0000) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            db_cnt_q     <= '0;
            state_q      <= IDLE;
            lock_cnt_q   <= '0;
            valid_q      <= '0;
            conflict_q   <= 1'b0;
        end else begin
            sync1_q      <= raw_buttons;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            valid_q      <= valid_d;
            conflict_q   <= conflict_d;
        end
    end

    assign vote_io.candidate1_vote_valid = valid_q[0];
    assign vote_io.candidate2_vote_valid = valid_q[1];
    assign vote_io.candidate3_vote_valid = valid_q[2];
    assign vote_io.candidate4_vote_valid = valid_q[3];
    assign vote_io.conflict              = conflict_q;
    assign vote_io.busy                  = (state_q != IDLE);

endmodule

// File: tb/tb_vote_button_conditioner.sv
// Directed bench for vote_button_conditioner with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8.
// Edge index 0 is the first rising edge that samples newly driven inputs.
module tb_vote_button_conditioner;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    vote_button_conditioner_if vif ();

    vote_button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .LOCKOUT_CYCLES (8),
        .CNT_WIDTH      (16)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .vote_io(vif)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] btn;
        logic       mode;
        int         hold;
        logic [3:0] exp_mask;
        int         exp_pulses;
        int         exp_vcyc;
        int         exp_ccyc;
        int         exp_cpulses;
        int         exp_busy;
        int         exp_rel;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] vmask();
        return {vif.candidate4_vote_valid, vif.candidate3_vote_valid,
                vif.candidate2_vote_valid, vif.candidate1_vote_valid};
    endfunction

    task automatic set_btn(input logic [3:0] b);
        vif.button1 = b[0];
        vif.button2 = b[1];
        vif.button3 = b[2];
        vif.button4 = b[3];
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic watch(input int n, output int first_v, output int pulses,
                         output logic [3:0] vm, output int first_c, output int cpulses,
                         output int busy_hi, output int multi);
        logic [3:0] m;
        first_v = -1; pulses = 0; vm = 4'b0000;
        first_c = -1; cpulses = 0; busy_hi = 0; multi = 0;
        for (int c = 0; c < n; c++) begin
            tick();
            m = vmask();
            if (m != 4'b0000) begin
                pulses++;
                vm = vm | m;
                if (first_v < 0) first_v = c;
            end
            if ($countones(m) > 1) multi++;
            if (vif.conflict) begin
                cpulses++;
                if (first_c < 0) first_c = c;
            end
            if (vif.busy) busy_hi++;
        end
    endtask

    // Returns the edge index (after release) at which busy is first seen low.
    task automatic wait_idle(input int limit, output int n);
        n = limit;
        for (int c = 0; c < limit; c++) begin
            tick();
            if (!vif.busy) begin
                n = c;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int fv, np, fc, nc, bh, mu, rel, busy_rise, busy_fall, p1, p4;
        logic [3:0] vm;
        int durs[10];
        logic lvl;

        vecs[0] = '{4'b0010, 1'b0, 30,  4'b0010, 1,  6, -1, 0, 24, 6};
        vecs[1] = '{4'b1100, 1'b0, 30,  4'b0000, 0, -1,  6, 1, 24, 6};
        vecs[2] = '{4'b0100, 1'b0, 30,  4'b0100, 1,  6, -1, 0, 24, 6};
        vecs[3] = '{4'b0001, 1'b1, 30,  4'b0000, 0, -1, -1, 0,  0, 0};
        vecs[4] = '{4'b0001, 1'b0, 30,  4'b0001, 1,  6, -1, 0, 24, 6};
        vecs[5] = '{4'b1000, 1'b0, 100, 4'b1000, 1,  6, -1, 0, 94, 6};
        vecs[6] = '{4'b1111, 1'b0, 30,  4'b0000, 0, -1,  6, 1, 24, 6};
        vecs[7] = '{4'b0101, 1'b1, 30,  4'b0000, 0, -1, -1, 0,  0, 0};

        reset = 1'b1;
        vif.mode = 1'b0;
        set_btn(4'b0000);
        repeat (3) tick();
        check("reset valids", int'(vmask()), 0);
        check("reset busy", int'(vif.busy), 0);
        check("reset conflict", int'(vif.conflict), 0);
        reset = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 8; i++) begin
            vif.mode = vecs[i].mode;
            set_btn(vecs[i].btn);
            watch(vecs[i].hold, fv, np, vm, fc, nc, bh, mu);
            check($sformatf("v%0d pulses", i), np, vecs[i].exp_pulses);
            check($sformatf("v%0d mask", i), int'(vm), int'(vecs[i].exp_mask));
            check($sformatf("v%0d valid_edge", i), fv, vecs[i].exp_vcyc);
            check($sformatf("v%0d conflict_edge", i), fc, vecs[i].exp_ccyc);
            check($sformatf("v%0d conflict_pulses", i), nc, vecs[i].exp_cpulses);
            check($sformatf("v%0d busy_cycles", i), bh, vecs[i].exp_busy);
            check($sformatf("v%0d onehot", i), mu, 0);
            set_btn(4'b0000);
            wait_idle(40, rel);
            check($sformatf("v%0d release_to_idle", i), rel, vecs[i].exp_rel);
            repeat (10) tick();
        end
        vif.mode = 1'b0;

        // Bounce: runs of 1-3 cycles never reach the debounce threshold.
        durs = '{1, 2, 3, 1, 2, 3, 2, 1, 3, 2};
        lvl = 1'b1;
        np = 0;
        bh = 0;
        for (int s = 0; s < 10; s++) begin
            set_btn(lvl ? 4'b0001 : 4'b0000);
            for (int k = 0; k < durs[s]; k++) begin
                tick();
                if (vmask() != 4'b0000) np++;
                if (vif.busy) bh++;
            end
            lvl = ~lvl;
        end
        check("bounce no_valid", np, 0);
        check("bounce no_busy", bh, 0);
        set_btn(4'b0001);
        watch(30, fv, np, vm, fc, nc, bh, mu);
        check("bounce valid_edge", fv, 6);
        check("bounce pulses", np, 1);
        check("bounce mask", int'(vm), 1);
        set_btn(4'b0000);
        wait_idle(40, rel);
        check("bounce release", rel, 6);
        repeat (10) tick();

        // Held button4, button1 pressed inside lockout must be ignored.
        set_btn(4'b1000);
        p1 = 0; p4 = 0; fv = -1; nc = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (vif.candidate1_vote_valid) p1++;
            if (vif.candidate4_vote_valid) begin
                p4++;
                if (fv < 0) fv = c;
            end
            if (vif.conflict) nc++;
            if (c == 6) set_btn(4'b1001);
        end
        check("lockout c4_pulses", p4, 1);
        check("lockout c4_edge", fv, 6);
        check("lockout c1_ignored", p1, 0);
        check("lockout no_conflict", nc, 0);
        set_btn(4'b0000);
        wait_idle(40, rel);
        check("lockout release", rel, 6);
        repeat (10) tick();

        // Short press, mode flipped to display mid-lockout: lockout length unchanged.
        set_btn(4'b0010);
        busy_rise = -1; busy_fall = -1; np = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (vmask() != 4'b0000) np++;
            if (vif.busy && busy_rise < 0) busy_rise = c;
            if (!vif.busy && busy_rise >= 0 && busy_fall < 0) busy_fall = c;
            if (c == 7) set_btn(4'b0000);
            if (c == 8) vif.mode = 1'b1;
        end
        check("modelock pulses", np, 1);
        check("modelock busy_rise", busy_rise, 6);
        check("modelock busy_fall", busy_fall, 15);
        vif.mode = 1'b0;
        repeat (10) tick();

        // Reset three cycles into lockout with button3 still held.
        set_btn(4'b0100);
        fv = -1; np = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (vmask() != 4'b0000) begin
                np++;
                if (fv < 0) fv = c;
            end
        end
        check("rstlock first_edge", fv, 6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstlock valids", int'(vmask()), 0);
        check("rstlock busy", int'(vif.busy), 0);
        check("rstlock conflict", int'(vif.conflict), 0);
        fv = -1; np = 0; vm = 4'b0000;
        for (int c = 11; c < 40; c++) begin
            tick();
            if (vmask() != 4'b0000) begin
                np++;
                vm = vm | vmask();
                if (fv < 0) fv = c;
            end
        end
        check("rstlock revote_edge", fv, 17);
        check("rstlock revote_pulses", np, 1);
        check("rstlock revote_mask", int'(vm), 4);
        set_btn(4'b0000);
        wait_idle(40, rel);
        check("rstlock release", rel, 6);
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
